// File: rtl/kernel_stream_sink_stallgen_if.sv
// Stream-sink bundle: pipeline write side, stall feedback, consumer read side and status.
// The master modport is the environment (pipeline plus consumer); the slave modport is the sink.
interface kernel_stream_sink_stallgen_if #(
  parameter int DATAW = 32,
  parameter int ADDRW = 3
) ();
  logic [DATAW-1:0] in_data;
  logic             in_valid;
  logic             stall;
  logic [DATAW-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [ADDRW:0]   level;
  logic [31:0]      words_out;

  modport master (
    output in_data, in_valid, out_ready,
    input  stall, out_data, out_valid, level, words_out
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output stall, out_data, out_valid, level, words_out
  );
endinterface

// File: rtl/kernel_stream_sink_stallgen.sv
// Sink of the leaf-node stall protocol: a FWFT FIFO buffers pipeline results.
// A registered stall freezes the pipeline once occupancy reaches DEPTH-MARGIN.
module kernel_stream_sink_stallgen #(
  parameter int DATAW  = 32,
  parameter int DEPTH  = 8,
  parameter int ADDRW  = 3,
  parameter int MARGIN = 1
) (
  input logic                          clk,
  input logic                          rst,
  kernel_stream_sink_stallgen_if.slave bus
);
  localparam logic [ADDRW:0] THRESH = (ADDRW+1)'(DEPTH - MARGIN);

  logic [DATAW-1:0] mem [DEPTH];
  logic [ADDRW-1:0] wr_ptr_reg;
  logic [ADDRW-1:0] rd_ptr_reg;
  logic [ADDRW:0]   level_reg;
  logic [ADDRW:0]   level_next;
  logic             stall_reg;
  logic [31:0]      words_out_reg;
  logic             wr;
  logic             rd;

  // A word offered while stalled is held upstream, so it is simply not taken here.
  assign wr = bus.in_valid & ~stall_reg;
  assign rd = (level_reg != '0) & bus.out_ready;

  always_comb begin
    level_next = level_reg + (ADDRW+1)'(wr) - (ADDRW+1)'(rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      stall_reg     <= 1'b0;
      words_out_reg <= '0;
    end else begin
      if (wr) wr_ptr_reg <= wr_ptr_reg + ADDRW'(1);
      if (rd) begin
        rd_ptr_reg    <= rd_ptr_reg + ADDRW'(1);
        words_out_reg <= words_out_reg + 32'd1;
      end
      level_reg <= level_next;
      // Registering the compare on level_next keeps stall == (level >= THRESH).
      stall_reg <= (level_next >= THRESH);
    end
  end

  // Storage has no reset; stale entries are unreachable once level returns to 0.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr_reg] <= bus.in_data;
  end

  assign bus.stall     = stall_reg;
  assign bus.out_valid = (level_reg != '0);
  assign bus.out_data  = mem[rd_ptr_reg];
  assign bus.level     = level_reg;
  assign bus.words_out = words_out_reg;
endmodule

// File: tb/tb_kernel_stream_sink_stallgen.sv
// Directed bench for kernel_stream_sink_stallgen: stalling upstream producer, occupancy model
// and in-order scoreboard, plus hand-computed checkpoints at the interesting edges.
module tb_kernel_stream_sink_stallgen;
  localparam int DATAW = 32, DEPTH = 8, ADDRW = 3, MARGIN = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  kernel_stream_sink_stallgen_if #(.DATAW(DATAW), .ADDRW(ADDRW)) bus ();

  kernel_stream_sink_stallgen #(
    .DATAW(DATAW), .DEPTH(DEPTH), .ADDRW(ADDRW), .MARGIN(MARGIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          vectors = 0;
  int          fails   = 0;
  int          m_level = 0;
  int          max_level = 0;
  logic [31:0] m_words = '0;
  logic [31:0] q[$];
  logic [31:0] prod_data = 32'd1;
  logic [31:0] prod_last = 32'd0;
  logic        prod_en   = 1'b0;
  logic        rand_mode = 1'b0;
  logic        seen_stall = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One clock: predict wr/rd from the model, check the head word, advance, check state.
  task automatic cycle();
    logic m_stall, m_wr, m_rd, held;
    m_stall = (m_level >= DEPTH - MARGIN);
    m_wr    = bus.in_valid && !m_stall;
    m_rd    = (m_level != 0) && bus.out_ready;
    if (m_rd && !rst) begin
      chk("out_data", bus.out_data, q[0]);
      void'(q.pop_front());
    end
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      m_level = 0;
      m_words = '0;
    end else begin
      if (m_wr) begin
        q.push_back(bus.in_data);
        prod_data = prod_data + 32'd1;
      end
      m_level = m_level + int'(m_wr) - int'(m_rd);
      if (m_rd) m_words = m_words + 32'd1;
    end
    if (m_level > max_level) max_level = m_level;
    if (bus.stall) seen_stall = 1'b1;
    chk("level", 32'(bus.level), 32'(m_level));
    chk("stall", 32'(bus.stall), 32'(m_level >= DEPTH - MARGIN));
    chk("out_valid", 32'(bus.out_valid), 32'(m_level != 0));
    chk("words_out", bus.words_out, m_words);
    held = bus.in_valid && !(m_wr && !rst);
    if (rand_mode) begin
      if (!held) bus.in_valid = prod_en && (prod_data <= prod_last) && ($urandom_range(0, 1) == 1);
      bus.out_ready = ($urandom_range(0, 1) == 1);
    end else begin
      bus.in_valid = prod_en && (prod_data <= prod_last) && !rst;
    end
    bus.in_data = prod_data;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while ((q.size() != 0 || bus.in_valid) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_done", 32'(q.size()) + 32'(bus.in_valid), 32'd0);
  endtask

  initial begin
    int n;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Power-up reset.
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_words", bus.words_out, 32'd0);

    // Pass-through of 1..20 with the consumer always ready.
    prod_en = 1'b1; prod_data = 32'd1; prod_last = 32'd20;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = prod_data;
    seen_stall = 1'b0;
    drain(60);
    chk("pt_words_out", bus.words_out, 32'd20);
    chk("pt_no_stall", 32'(seen_stall), 32'd0);

    // Fill with 1..10 and consumer stalled: level parks at 7, words 8..10 held upstream.
    bus.out_ready = 1'b0;
    prod_data = 32'd1; prod_last = 32'd10;
    bus.in_valid = 1'b1; bus.in_data = prod_data;
    for (int i = 0; i < 10; i++) cycle();
    chk("fill_level", 32'(bus.level), 32'd7);
    chk("fill_stall", 32'(bus.stall), 32'd1);
    chk("fill_next_word", bus.in_data, 32'd8);

    // Release one entry: word 1 leaves, stall drops, then word 8 is captured.
    bus.out_ready = 1'b1;
    chk("rel_head", bus.out_data, 32'd1);
    cycle();
    bus.out_ready = 1'b0;
    chk("rel_level", 32'(bus.level), 32'd6);
    chk("rel_stall", 32'(bus.stall), 32'd0);
    cycle();
    chk("rel_capture", bus.in_data, 32'd9);
    chk("rel_level2", 32'(bus.level), 32'd7);
    drain(60);
    chk("rel_words_out", bus.words_out, 32'd30);

    // Simultaneous read and offered write exactly at the threshold.
    bus.out_ready = 1'b0;
    prod_data = 32'd11; prod_last = 32'd18;
    bus.in_valid = 1'b1; bus.in_data = prod_data;
    for (int i = 0; i < 9; i++) cycle();
    chk("thr_level", 32'(bus.level), 32'd7);
    chk("thr_held", bus.in_data, 32'd18);
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    chk("thr_level_drop", 32'(bus.level), 32'd6);
    chk("thr_stall_drop", 32'(bus.stall), 32'd0);
    chk("thr_still_held", bus.in_data, 32'd18);
    cycle();
    chk("thr_captured", bus.in_data, 32'd19);
    chk("thr_level_back", 32'(bus.level), 32'd7);
    drain(60);
    chk("thr_words_out", bus.words_out, 32'd38);

    // 200 words with random valid/ready; pointers wrap 25 times.
    rand_mode = 1'b1;
    max_level = 0;
    prod_data = 32'd1000; prod_last = 32'd1199;
    bus.in_valid = 1'b1; bus.in_data = prod_data;
    n = 0;
    while (m_words != 32'd238 && n < 5000) begin
      cycle();
      n++;
    end
    rand_mode = 1'b0;
    chk("rnd_words_out", bus.words_out, 32'd238);
    chk("rnd_level_le7", 32'(max_level <= 7), 32'd1);

    // Reset with words buffered: nothing from before reset may come out.
    bus.out_ready = 1'b0;
    prod_data = 32'd500; prod_last = 32'd503;
    bus.in_valid = 1'b1; bus.in_data = prod_data;
    for (int i = 0; i < 5; i++) cycle();
    chk("pre_rst_level", 32'(bus.level), 32'd4);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    chk("mrst_stall", 32'(bus.stall), 32'd0);
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_level", 32'(bus.level), 32'd0);
    chk("mrst_words", bus.words_out, 32'd0);
    prod_data = 32'd600; prod_last = 32'd603;
    bus.in_valid = 1'b1; bus.in_data = prod_data;
    cycle();
    chk("post_rst_head", bus.out_data, 32'd600);
    drain(40);
    chk("post_rst_words", bus.words_out, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
